// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter for a single memory port, one outstanding transaction
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed LSU priority.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_resp_valid,
   output logic [DATA_W-1:0]     ifu_rdata,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wmask,
   output logic                  lsu_resp_valid,
   output logic [DATA_W-1:0]     lsu_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic                  owner
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]          r_state;
   logic                r_owner;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wen;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wmask;

   logic w_idle;
   logic w_pick_lsu;
   logic w_grant_lsu;
   logic w_grant_ifu;
   logic w_resp;

   assign w_idle = (r_state == IDLE) && !rst;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_lsu;

   // On a conflict the side that did not win last time goes first.
   assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_lsu <= 1'b0;
      end else if (w_grant_lsu || w_grant_ifu) begin
         r_last_lsu <= w_grant_lsu;
      end
   end
`else
   assign w_pick_lsu = lsu_req_valid;
`endif

   assign w_grant_lsu = w_idle && w_pick_lsu;
   assign w_grant_ifu = w_idle && ifu_req_valid && !w_pick_lsu;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_lsu) begin
                  r_state <= REQ;
                  r_owner <= 1'b1;
                  r_addr  <= lsu_addr;
                  r_wen   <= lsu_wen;
                  r_wdata <= lsu_wdata;
                  r_wmask <= lsu_wmask;
               end else if (w_grant_ifu) begin
                  r_state <= REQ;
                  r_owner <= 1'b0;
                  r_addr  <= ifu_addr;
                  r_wen   <= 1'b0;
                  r_wdata <= '0;
                  r_wmask <= '0;
               end
            end
            REQ: begin
               if (mem_req_ready) r_state <= WAIT;
            end
            WAIT: begin
               if (mem_resp_valid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Responses outside WAIT (including after a reset) never reach a requester.
   assign w_resp = (r_state == WAIT) && mem_resp_valid && !rst;

   assign ifu_req_ready  = w_grant_ifu;
   assign lsu_req_ready  = w_grant_lsu;
   assign ifu_resp_valid = w_resp && !r_owner;
   assign lsu_resp_valid = w_resp && r_owner;
   assign ifu_rdata      = mem_rdata;
   assign lsu_rdata      = mem_rdata;
   assign mem_req_valid  = (r_state == REQ);
   assign mem_addr       = r_addr;
   assign mem_wen        = r_wen;
   assign mem_wdata      = r_wdata;
   assign mem_wmask      = r_wmask;
   assign busy           = (r_state != IDLE);
   assign owner          = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        owner;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Drives mem_req_ready for one cycle then a one-cycle response.
   task automatic complete(input logic [31:0] data);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = data;
      step();
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({busy, owner, mem_req_valid, mem_wen} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, owner, mem_req_valid, mem_wen}); end
      checks++; if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin errors++; $display("FAIL reset_payload got %h exp 0", {mem_addr, mem_wdata, mem_wmask}); end
      checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0000) begin errors++; $display("FAIL reset_hs got %b exp 0000", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}); end
   endtask

   task automatic test_ifu_fetch();
      ifu_req_valid = 1'b1;
      ifu_addr = 32'h8000_0000;
      #1;
      checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b exp 1", ifu_req_ready); end
      step();
      ifu_req_valid = 1'b0;
      ifu_addr = 32'h1234_5678;
      mem_req_ready = 1'b1;
      #1;
      checks++; if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 32'h8000_0000, 1'b0}) begin errors++; $display("FAIL fetch_req got %b/%h/%b exp 1/80000000/0", mem_req_valid, mem_addr, mem_wen); end
      checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_lsu_resp_n1 got %b exp 0", lsu_resp_valid); end
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h0000_0013;
      #1;
      checks++; if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h0000_0013}) begin errors++; $display("FAIL fetch_resp got %b/%h exp 1/00000013", ifu_resp_valid, ifu_rdata); end
      checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_lsu_resp_n2 got %b exp 0", lsu_resp_valid); end
      step();
      mem_resp_valid = 1'b0;
      #1;
      checks++; if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin errors++; $display("FAIL fetch_done got %b exp 000", {busy, ifu_resp_valid, lsu_resp_valid}); end
   endtask

   task automatic test_lsu_store_backpressure();
      lsu_req_valid = 1'b1;
      lsu_wen = 1'b1;
      lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF;
      lsu_wmask = 4'hF;
      #1;
      checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin errors++; $display("FAIL store_ready got %b exp 10", {lsu_req_ready, ifu_req_ready}); end
      step();
      lsu_req_valid = 1'b0;
      lsu_wen = 1'b0;
      lsu_addr = 32'h0;
      lsu_wdata = 32'h5555_5555;
      lsu_wmask = 4'h1;
      for (int c = 0; c < 4; c++) begin
         mem_req_ready = (c == 3);
         #1;
         checks++;
         if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, owner} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL store_hold%0d got %b/%h/%b/%h/%h exp 1/80001000/1/deadbeef/f", c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
         end
         step();
      end
      mem_req_ready = 1'b0;
      #1;
      checks++; if ({mem_req_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL store_wait got %b exp 00", {mem_req_valid, lsu_resp_valid}); end
      step();
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h0;
      #1;
      checks++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin errors++; $display("FAIL store_resp got %b exp 10", {lsu_resp_valid, ifu_resp_valid}); end
      step();
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic exp_lsu2;
`ifdef ARB_ROUND_ROBIN_EN
      exp_lsu2 = 1'b0;
`else
      exp_lsu2 = 1'b1;
`endif
      do_reset();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
      lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      #1;
      checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin errors++; $display("FAIL simul1_grant got %b exp 10", {lsu_req_ready, ifu_req_ready}); end
      step();
      checks++; if ({owner, mem_addr} !== {1'b1, 32'h8000_2000}) begin errors++; $display("FAIL simul1_owner got %b/%h exp 1/80002000", owner, mem_addr); end
      complete(32'hAAAA_0001);
      #1;
      checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu2, ~exp_lsu2}) begin errors++; $display("FAIL simul2_grant got %b exp %b", {lsu_req_ready, ifu_req_ready}, {exp_lsu2, ~exp_lsu2}); end
      step();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      checks++; if (owner !== exp_lsu2) begin errors++; $display("FAIL simul2_owner got %b exp %b", owner, exp_lsu2); end
      complete(32'hAAAA_0002);
   endtask

   task automatic test_requests_while_busy();
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
      step();
      lsu_req_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
      #1;
      checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL busy_req_ready got %b exp 0", ifu_req_ready); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      checks++; if ({ifu_req_ready, busy} !== 2'b01) begin errors++; $display("FAIL busy_wait_ready got %b exp 01", {ifu_req_ready, busy}); end
      mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0000;
      #1;
      checks++; if ({ifu_req_ready, lsu_resp_valid, ifu_resp_valid, lsu_rdata} !== {3'b010, 32'hCAFE_0000}) begin errors++; $display("FAIL busy_resp got %b/%h exp 010/cafe0000", {ifu_req_ready, lsu_resp_valid, ifu_resp_valid}, lsu_rdata); end
      step();
      mem_resp_valid = 1'b0;
      #1;
      checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL busy_idle_grant got %b exp 1", ifu_req_ready); end
      step();
      ifu_req_valid = 1'b0;
      checks++; if ({owner, mem_addr, mem_req_valid} !== {1'b0, 32'h8000_0080, 1'b1}) begin errors++; $display("FAIL busy_ifu_req got %b/%h/%b exp 0/80000080/1", owner, mem_addr, mem_req_valid); end
      complete(32'h1);
   endtask

   task automatic test_reset_mid_op();
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_4000;
      lsu_wdata = 32'h1234_ABCD; lsu_wmask = 4'h3;
      step();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      checks++; if ({busy, mem_req_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_inwait got %b exp 10", {busy, mem_req_valid}); end
      do_reset();
      #1;
      checks++; if ({busy, owner, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== 72'h0) begin errors++; $display("FAIL rstmid_state got %b/%h/%h/%h exp 0", {busy, owner, mem_req_valid, mem_wen}, mem_addr, mem_wdata, mem_wmask); end
      mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      #1;
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_resp got %b exp 00", {ifu_resp_valid, lsu_resp_valid}); end
      step();
      mem_resp_valid = 1'b0;
      checks++; if ({busy, mem_req_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_after got %b exp 00", {busy, mem_req_valid}); end
   endtask

   task automatic test_stray_response();
      mem_resp_valid = 1'b1; mem_rdata = 32'h0F0F_0F0F;
      #1;
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL stray_resp got %b exp 00", {ifu_resp_valid, lsu_resp_valid}); end
      step();
      mem_resp_valid = 1'b0;
      step();
      checks++; if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 4'b0000) begin errors++; $display("FAIL stray_state got %b exp 0000", {busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid}); end
   endtask

   initial begin
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      test_reset();
      test_ifu_fetch();
      test_lsu_store_backpressure();
      test_simultaneous();
      test_requests_while_busy();
      test_reset_mid_op();
      test_stray_response();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares the single CPU memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU). It sits between those units and the memory/bus interface. It latches one request at a time, drives it downstream with a valid/ready handshake, and returns the response only to the requester that issued it. It allows exactly one outstanding transaction, so it also serialises fetch and data access for the multi-cycle core.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; DATA_W/8 byte-mask bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU request present (read only)
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response, one-cycle pulse
- ifu_rdata  out  DATA_W  IFU read data, valid with ifu_resp_valid
- lsu_req_valid  in  1  LSU request present
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid  out  1  LSU response (load data or store ack), one-cycle pulse
- lsu_rdata  out  DATA_W  LSU load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request payload
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DATA_W  downstream read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IFU, 1 = LSU; meaningful while busy

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: when any req_valid is high, select a winner. The winner's req_ready is driven high combinationally in the same cycle. Latch the payload and owner, then go to REQ. A losing requester sees req_ready=0 and must hold its request.
- IFU payload: wen=0, wdata=0, wmask=0.
- REQ: mem_req_valid=1 with the latched payload held stable. Go to WAIT when mem_req_ready=1.
- WAIT: on mem_resp_valid, drive the owner's resp_valid=1 and rdata=mem_rdata combinationally, then go to IDLE. The other requester's resp_valid stays 0.
- Arbitration (default): fixed priority, LSU wins over IFU.
- req_ready is never asserted outside IDLE. At most one req_ready is high per cycle.
- mem_resp_valid outside WAIT is ignored.
- Reset values: state IDLE, owner 0, mem_req_valid 0, mem_addr/wdata/wmask/wen 0, both req_ready 0, both resp_valid 0, busy 0.
- Reset mid-transaction drops the transaction. No response is delivered for it, and any response arriving after reset is ignored.

## Timing
- Accept at cycle N (req_valid and req_ready both high).
- mem_req_valid is high from cycle N+1 until the handshake completes.
- Minimum round trip: mem_req_ready=1 at N+1 and mem_resp_valid at N+2 give a response at N+2. The next acceptance is possible at N+3.
- Throughput: at most one transaction per 3 cycles.
- Latched payload does not change from N+1 until return to IDLE, regardless of upstream inputs.
- Both req_valid high in IDLE in the same cycle: exactly one is granted, per the arbitration rule.
- rdata outputs are only meaningful in the resp_valid cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration. A 1-bit last-grant register, reset to 0 (IFU), is updated on every accept. On a conflict, the requester not granted last wins. With a single requester, that requester is granted.
- ARB_ROUND_ROBIN_EN undefined: fixed LSU priority as described above; no last-grant register exists.

## Test plan
- Single IFU fetch:
  - Stimulus: ifu_req_valid with addr 0x80000000; mem_req_ready=1 immediately; resp with rdata 0x00000013 one cycle later.
  - Required: ifu_req_ready at N, mem_addr=0x80000000 with mem_req_valid at N+1, ifu_resp_valid=1 with ifu_rdata=0x00000013 at N+2, lsu_resp_valid=0 throughout.
- LSU store with backpressure:
  - Stimulus: lsu_wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready held 0 for 3 cycles.
  - Required: mem_req_valid and payload stable for 4 cycles; lsu_resp_valid on the response.
- Simultaneous requests:
  - Stimulus: IFU and LSU valid in the same cycle, repeated twice.
  - Required: fixed build grants LSU both times; round-robin build grants LSU first and IFU second.
- Requests while busy:
  - Stimulus: IFU raises req_valid while in WAIT.
  - Required: ifu_req_ready stays 0 until IDLE, then the IFU request is granted.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT, then pulse mem_resp_valid after reset.
  - Required: all outputs at reset values and no resp_valid on either requester.
- Stray response:
  - Stimulus: mem_resp_valid in IDLE.
  - Required: no resp_valid and no state change.
